// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
//   Shared definitions for the pushbutton event classifier: the FSM state
//   encoding and its width.
// -----------------------------------------------------------------------------
package button_event_pkg;

  localparam int STATE_W = 3;

  // IDLE   : button released, nothing pending
  // PRESS1 : first press in progress, measuring hold time
  // WAIT2  : first press released, waiting for a possible second press
  // PRESS2 : second press in progress (double click pending)
  // LONG   : hold reached the long threshold, waiting for release
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

endpackage : button_event_pkg

// File: rtl/button_event_gen_tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//   Cycle divider (0..TICK_DIV-1) feeding a saturating tick counter.
//
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   asynchronous active-high reset
//     clr   in   synchronous clear of divider and tick counter (wins over en)
//     en    in   count enable
//     ticks out  elapsed ticks, saturating at all-ones
//
//   The ticks output already includes the cycle currently in progress: it is
//   the value the counter will hold after this clock edge. A comparison
//   ticks >= N made at an edge therefore fires on exactly the N*TICK_DIV-th
//   edge after the clear, so the consumer's registered reaction lands on
//   that edge rather than one cycle later.
// -----------------------------------------------------------------------------
module tick_timer #(
  parameter int TICK_DIV = 156250,
  parameter int TICK_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [TICK_W-1:0] ticks
);

  localparam int                DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICKS_MAX = '1;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [TICK_W-1:0] ticks_q;
  logic [TICK_W-1:0] ticks_d;
  logic              wrap;

  always_comb begin
    wrap = en && (div_q == DIV_LAST);

    // Look-ahead tick value: counter plus the tick completing this cycle.
    ticks = ticks_q;
    if (wrap && (ticks_q != TICKS_MAX)) begin
      ticks = ticks_q + 1'b1;
    end

    div_d   = div_q;
    ticks_d = ticks_q;
    if (clr) begin
      div_d   = '0;
      ticks_d = '0;
    end else if (en) begin
      div_d   = wrap ? '0 : div_q + 1'b1;
      ticks_d = ticks;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      ticks_q <= '0;
    end else begin
      div_q   <= div_d;
      ticks_q <= ticks_d;
    end
  end

endmodule : tick_timer

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//   Classifies presses of one debounced pushbutton into single-cycle pulses:
//   short click, double click and long hold.
//
//   Parameters:
//     TICK_DIV     clk cycles per timer tick (>= 2)
//     LONG_TICKS   hold duration, in ticks, classifying a long press (>= 1)
//     DCLICK_TICKS max release gap, in ticks, before a second press (>= 1)
//     TICK_W       tick counter width, must hold max(LONG_TICKS, DCLICK_TICKS)
//
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     btn_in       in   debounced button level, active high
//     short_pulse  out  one-cycle pulse for a single short click
//     double_pulse out  one-cycle pulse for a double click
//     long_pulse   out  one-cycle pulse when a hold reaches LONG_TICKS
//     held         out  high while in LONG
//     busy         out  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int TICK_DIV     = 156250,
  parameter int LONG_TICKS   = 1000,
  parameter int DCLICK_TICKS = 300,
  parameter int TICK_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic held,
  output logic busy
);

  localparam logic [TICK_W-1:0] LONG_T   = TICK_W'(LONG_TICKS);
  localparam logic [TICK_W-1:0] DCLICK_T = TICK_W'(DCLICK_TICKS);

  state_t            state_q;
  state_t            state_d;
  logic              btn_q;
  logic              rise;
  logic              fall;
  logic              short_q;
  logic              short_d;
  logic              double_q;
  logic              double_d;
  logic              long_q;
  logic              long_d;
  logic              held_q;
  logic              busy_q;
  logic [TICK_W-1:0] ticks;
  logic              timer_clr;
  logic              timer_en;
  logic              long_to;
  logic              dclick_to;

  // btn_q resets high, so a button held through reset shows no rise until it
  // has been released and pressed again.
  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;

  // Every state change restarts the measurement window.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = (state_q != IDLE);

  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .ticks (ticks)
  );

  assign long_to   = (ticks >= LONG_T);
  assign dclick_to = (ticks >= DCLICK_T);

  // Next-state and pulse decode. Button edges are tested before timeouts so
  // that an edge arriving on the timeout cycle takes priority.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (long_to) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (dclick_to) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (long_to) begin
          // The pending double click is dropped in favour of the long hold.
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge-detect and output registers. busy/held are registered from
  // the next state so they change on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      btn_q    <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_in;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      held_q   <= (state_d == LONG);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign short_pulse  = short_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign held         = held_q;
  assign busy         = busy_q;

  // Each decision takes exactly one branch, so the pulses are mutually
  // exclusive.
  a_pulses_exclusive : assert property (
    @(posedge clk) disable iff (rst) $onehot0({short_q, double_q, long_q})
  );

endmodule : button_event_gen
